sine_sweep_sched: RTL and testbench
===================================

Name: sine_sweep_sched

Overview:
- Sequencer that drives the `period` and `phase_offset` inputs of the variable-frequency sine generator.
- Steps `period` from a start value to an end value with a programmable dwell per step, for frequency sweeps and lock-point search.
- Slews `phase_offset` toward a target one LUT step at a time, so the sine/cosine reference never jumps in phase.
- Sits between the config register bank and the sine generator in the locking loop.

Parameters:
- CFG_W, 32, width of period/dwell/step/slew config words (matches config_reg_width).
- LUT_W, 10, sine LUT index width (matches sine_lut_width); phase step = 2*pi/2^LUT_W.

Ports:
- clk  in  1  250 MHz clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; begins a sweep when idle.
- abort  in  1  single-cycle pulse; terminates a sweep.
- loop  in  1  1 = repeat sweep until abort; 0 = single pass.
- period_start  in  CFG_W  first period value.
- period_end  in  CFG_W  last period value; may be above or below period_start.
- period_step  in  CFG_W  magnitude of each period increment.
- dwell  in  CFG_W  clock cycles held at each period value; 0 is treated as 1.
- phase_target  in  LUT_W  desired phase offset.
- phase_slew_div  in  CFG_W  cycles between phase LSB moves; 0 = every cycle.
- period  out  CFG_W  to sine generator.
- phase_offset  out  LUT_W  to sine generator.
- busy  out  1  high while a sweep is active.
- done  out  1  single-cycle pulse at normal end of a non-looping sweep.
- step_strobe  out  1  single-cycle pulse on every period update inside a sweep.
- phase_settled  out  1  combinational: phase_offset == phase_target.

Behaviour:
- Reset values: period=0, phase_offset=0, busy=0, done=0, step_strobe=0, state=IDLE, all counters 0.
- FSM states: IDLE, DWELL, STEP, DONE. All outputs are registered except phase_settled.

IDLE:
- period holds its last value.
- On start (and no abort): latch period_start/end/step, dwell and loop into shadow registers.
- Next cycle: period = period_start, busy = 1, dwell counter cleared, go DWELL. Latency start -> new period is 1 cycle.
- Config input changes during a sweep are ignored until the next start.

DWELL:
- Counter increments each cycle.
- When counter == max(dwell_s,1)-1, go STEP. The period value is therefore held exactly max(dwell_s,1) cycles.

STEP (1 cycle):
- Direction: up if end_s >= start_s, else down.
- If period == end_s, or step_s == 0: with loop_s, period = start_s, step_strobe, go DWELL; otherwise go DONE.
- Otherwise period moves by min(step_s, |end_s - period|) toward end_s, step_strobe pulses, go DWELL.
- The period never overshoots end_s and never wraps past 0 or 2^CFG_W-1. The remaining-distance compare is done as a subtraction, not an add, so it cannot overflow.

DONE:
- done = 1 for one cycle, busy = 0, go IDLE. period keeps end_s.

abort:
- From any state, next cycle: state = IDLE, busy = 0, no done pulse, period frozen at its current value.
- abort has priority over a simultaneous start.
- start while busy is ignored.

Phase slew (runs independently of the FSM, always active):
- phase_target is live, not shadowed.
- A slew counter counts to max(phase_slew_div,1)-1, then fires a tick and clears.
- On a tick: diff = (phase_target - phase_offset) mod 2^LUT_W.
  - diff == 0: hold.
  - diff < 2^(LUT_W-1): phase_offset + 1.
  - diff >= 2^(LUT_W-1): phase_offset - 1. This takes the shortest path; exactly half-circle resolves to decrement.
- Wrap-around is modular: 2^LUT_W-1 -> 0 and 0 -> 2^LUT_W-1.
- A target change mid-slew takes effect on the next tick.

Optional Feature:
- Macro: SINE_SWEEP_BIDIR_EN.
- Defined: on reaching end_s in STEP, direction reverses and period steps back toward start_s with the same step/dwell and clamping, making a triangle sweep.
  - step_strobe pulses on the turnaround.
  - With loop_s = 0, the sweep ends (DONE) on returning to start_s.
  - With loop_s = 1, it reverses again at each endpoint.
- Undefined: sawtooth behaviour as above (jump to start_s). The direction-reversal register and its logic are absent.

Test Plan:
- start with start=100, end=130, step=10, dwell=4, loop=0 -> period sequence 100,110,120,130, each held 4 cycles; 3 step_strobe pulses; done 1 cycle after last dwell; busy low afterwards.
- start with start=50, end=27, step=10, dwell=0 -> period 50,40,30,27 (clamped), 1 cycle each; then done.
- loop=1, start=5, end=7, step=1, dwell=2; abort pulse during period 6 -> sequence 5,6,7,5,6,...; after abort, busy=0 next cycle, period stays 6, no done; a simultaneous start+abort is ignored.
- phase_target=1020 from phase_offset=2, slew_div=3 -> decrements 2,1,0,1023,1022,1021,1020, one step every 3 cycles; phase_settled goes high on reaching 1020. Target 512 from 0 -> decrements through 1023.
- step=0, start=80, loop=0 -> period 80 for dwell cycles, then done; no step_strobe. Reset asserted mid-sweep -> all outputs return to reset values immediately (asynchronous).
- With SINE_SWEEP_BIDIR_EN, start=0, end=2, step=1, dwell=1, loop=0 -> period 0,1,2,1,0, then done.

Source files
------------

// File: rtl/sine_sweep_sched.sv
// Period sweep and phase slew sequencer for the variable-frequency sine generator.
// Define SINE_SWEEP_BIDIR_EN for triangle (bidirectional) sweeps instead of sawtooth.
module sine_sweep_sched #(
  parameter int CFG_W = 32,
  parameter int LUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             loop,
  input  logic [CFG_W-1:0] period_start,
  input  logic [CFG_W-1:0] period_end,
  input  logic [CFG_W-1:0] period_step,
  input  logic [CFG_W-1:0] dwell,
  input  logic [LUT_W-1:0] phase_target,
  input  logic [CFG_W-1:0] phase_slew_div,
  output logic [CFG_W-1:0] period,
  output logic [LUT_W-1:0] phase_offset,
  output logic             busy,
  output logic             done,
  output logic             step_strobe,
  output logic             phase_settled
);

  localparam logic [CFG_W-1:0] ONE = CFG_W'(1);
  localparam logic [CFG_W-1:0] TWO = CFG_W'(2);

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    STEP,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CFG_W-1:0] start_s, end_s;
  logic [CFG_W-1:0] step_s, dwell_s;
  logic             loop_s;

  logic [CFG_W-1:0] cnt, cnt_nx;
  logic [CFG_W-1:0] period_nx;
  logic             busy_nx, done_nx;
  logic             strobe_nx;
  logic             latch;
  logic             short_in, short_sh;
  state_t           entry_in, entry_sh;

`ifdef SINE_SWEEP_BIDIR_EN
  logic             rev, rev_nx;
  logic [CFG_W-1:0] tgt, far;
`endif

  // Clamped move toward t; distances are subtractions so nothing overflows.
  function automatic logic [CFG_W-1:0] toward(
    input logic [CFG_W-1:0] p,
    input logic [CFG_W-1:0] t,
    input logic [CFG_W-1:0] s
  );
    logic [CFG_W-1:0] rem;
    if (p <= t) begin
      rem = t - p;
      return p + ((s < rem) ? s : rem);
    end
    rem = p - t;
    return p - ((s < rem) ? s : rem);
  endfunction

  // The STEP cycle counts toward the hold time, so DWELL runs dwell-1 cycles.
  assign short_in = (dwell <= ONE);
  assign short_sh = (dwell_s <= ONE);
  assign entry_in = short_in ? STEP : DWELL;
  assign entry_sh = short_sh ? STEP : DWELL;
  assign latch    = (state == IDLE) && start && !abort;

`ifdef SINE_SWEEP_BIDIR_EN
  assign tgt = rev ? start_s : end_s;
  assign far = rev ? end_s : start_s;
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    period_nx = period;
    busy_nx   = busy;
    done_nx   = 1'b0;
    strobe_nx = 1'b0;
`ifdef SINE_SWEEP_BIDIR_EN
    rev_nx    = rev;
`endif
    if (abort) begin
      state_nx = IDLE;
      busy_nx  = 1'b0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            period_nx = period_start;
            busy_nx   = 1'b1;
            cnt_nx    = '0;
            state_nx  = entry_in;
`ifdef SINE_SWEEP_BIDIR_EN
            rev_nx    = 1'b0;
`endif
          end
        end
        DWELL: begin
          if (cnt == dwell_s - TWO) begin
            cnt_nx   = '0;
            state_nx = STEP;
          end else begin
            cnt_nx = cnt + ONE;
          end
        end
        STEP: begin
          cnt_nx = '0;
`ifdef SINE_SWEEP_BIDIR_EN
          if (step_s == '0) begin
            if (loop_s) begin
              period_nx = start_s;
              strobe_nx = 1'b1;
              state_nx  = entry_sh;
            end else begin
              state_nx = DONE;
              done_nx  = 1'b1;
              busy_nx  = 1'b0;
            end
          end else if (period == tgt) begin
            if (rev && !loop_s) begin
              state_nx = DONE;
              done_nx  = 1'b1;
              busy_nx  = 1'b0;
            end else begin
              rev_nx    = !rev;
              period_nx = toward(period, far, step_s);
              strobe_nx = 1'b1;
              state_nx  = entry_sh;
            end
          end else begin
            period_nx = toward(period, tgt, step_s);
            strobe_nx = 1'b1;
            state_nx  = entry_sh;
          end
`else
          if ((period == end_s) || (step_s == '0)) begin
            if (loop_s) begin
              period_nx = start_s;
              strobe_nx = 1'b1;
              state_nx  = entry_sh;
            end else begin
              state_nx = DONE;
              done_nx  = 1'b1;
              busy_nx  = 1'b0;
            end
          end else begin
            period_nx = toward(period, end_s, step_s);
            strobe_nx = 1'b1;
            state_nx  = entry_sh;
          end
`endif
        end
        DONE: begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_strobe <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      period      <= period_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      step_strobe <= strobe_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_s <= '0;
      end_s   <= '0;
      step_s  <= '0;
      dwell_s <= '0;
      loop_s  <= 1'b0;
    end else if (latch) begin
      start_s <= period_start;
      end_s   <= period_end;
      step_s  <= period_step;
      dwell_s <= dwell;
      loop_s  <= loop;
    end
  end

`ifdef SINE_SWEEP_BIDIR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rev <= 1'b0;
    else      rev <= rev_nx;
  end
`endif

  logic [CFG_W-1:0] slew_cnt;
  logic             tick;
  logic [LUT_W-1:0] diff;
  logic [LUT_W-1:0] phase_nx;

  assign tick = (phase_slew_div == '0) ||
                (slew_cnt >= phase_slew_div - ONE);
  assign diff = phase_target - phase_offset;

  // Half-circle difference has its MSB set and therefore decrements.
  always_comb begin
    phase_nx = phase_offset;
    if (tick) begin
      unique case (1'b1)
        (diff == '0):
          phase_nx = phase_offset;
        (diff != '0) && !diff[LUT_W-1]:
          phase_nx = phase_offset + 1'b1;
        diff[LUT_W-1]:
          phase_nx = phase_offset - 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slew_cnt     <= '0;
      phase_offset <= '0;
    end else begin
      slew_cnt     <= tick ? '0 : slew_cnt + ONE;
      phase_offset <= phase_nx;
    end
  end

  assign phase_settled = (phase_offset == phase_target);

endmodule

// File: tb/tb_sine_sweep_sched.sv
// Scoreboard bench for sine_sweep_sched: sweep trace and phase slew queues.
// Build with SINE_SWEEP_BIDIR_EN to add the triangle sweep vector.
module tb_sine_sweep_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        loop = 1'b0;
  logic [31:0] period_start = '0;
  logic [31:0] period_end = '0;
  logic [31:0] period_step = '0;
  logic [31:0] dwell = '0;
  logic [9:0]  phase_target = '0;
  logic [31:0] phase_slew_div = '0;
  logic [31:0] period;
  logic [9:0]  phase_offset;
  logic        busy, done, step_strobe, phase_settled;

  int total = 0;
  int bad = 0;

  sine_sweep_sched dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .loop(loop),
    .period_start(period_start),
    .period_end(period_end),
    .period_step(period_step),
    .dwell(dwell),
    .phase_target(phase_target),
    .phase_slew_div(phase_slew_div),
    .period(period),
    .phase_offset(phase_offset),
    .busy(busy),
    .done(done),
    .step_strobe(step_strobe),
    .phase_settled(phase_settled)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic [31:0] period;
    logic        strobe;
    logic        done;
  } rec_t;

  typedef struct packed {
    logic [9:0] val;
    logic [7:0] gap;
  } ph_t;

  rec_t sb[$];
  ph_t  phq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic seg(input int p, input int n, input logic s);
    for (int i = 0; i < n; i++)
      sb.push_back('{busy: 1'b1, period: p, strobe: (i == 0) ? s : 1'b0,
                     done: 1'b0});
  endtask

  task automatic fin(input int p);
    sb.push_back('{busy: 1'b0, period: p, strobe: 1'b0, done: 1'b1});
  endtask

  task automatic php(input int v, input int g);
    phq.push_back('{val: v[9:0], gap: g[7:0]});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input int ps, input int pe, input int st,
                    input int dw, input logic lp);
    period_start = ps;
    period_end   = pe;
    period_step  = st;
    dwell        = dw;
    loop         = lp;
    start        = 1'b1;
    cyc(1);
    start        = 1'b0;
  endtask

  logic [9:0] ph_prev = '0;
  int         ph_gap = 0;

  always @(negedge clk) begin
    rec_t e, g;
    ph_t  pe;
    if (!rst) begin
      ph_prev = phase_offset;
      ph_gap  = 0;
    end else begin
      if (busy || done) begin
        g = '{busy: busy, period: period, strobe: step_strobe, done: done};
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sweep_extra: busy=%0b per=%0d stb=%0b done=%0b",
                   busy, period, step_strobe, done);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL sweep: got b%0b p%0d s%0b d%0b want b%0b p%0d s%0b d%0b",
                     g.busy, g.period, g.strobe, g.done,
                     e.busy, e.period, e.strobe, e.done);
          end
        end
      end
      ph_gap++;
      if (phase_offset != ph_prev) begin
        total++;
        if (phq.size() == 0) begin
          bad++;
          $display("FAIL phase_extra: got %0d", phase_offset);
        end else begin
          pe = phq.pop_front();
          if (phase_offset !== pe.val ||
              (pe.gap != 0 && ph_gap != int'(pe.gap))) begin
            bad++;
            $display("FAIL phase: got %0d gap %0d want %0d gap %0d",
                     phase_offset, ph_gap, pe.val, pe.gap);
          end
        end
        ph_gap = 0;
      end
      ph_prev = phase_offset;
    end
  end

  initial begin
    cyc(2);
    chk("rst_period", period, 0);
    chk("rst_phase", 32'(phase_offset), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_strobe", 32'(step_strobe), 0);
    rst = 1'b1;
    cyc(2);
    chk("idle_settled", 32'(phase_settled), 1);

    php(1, 0);
    php(2, 1);
    phase_target = 10'd2;
    cyc(5);
    chk("ph_at2", 32'(phase_offset), 2);

    php(1, 0);
    php(0, 3);
    php(1023, 3);
    php(1022, 3);
    php(1021, 3);
    php(1020, 3);
    phase_target   = 10'd1020;
    phase_slew_div = 3;
    cyc(12);
    chk("ph_midslew_settled", 32'(phase_settled), 0);
    cyc(14);
    chk("ph_at1020", 32'(phase_offset), 1020);
    chk("ph_settled", 32'(phase_settled), 1);

    php(1021, 0);
    php(1022, 1);
    php(1023, 1);
    php(0, 1);
    phase_slew_div = 0;
    phase_target   = 10'd0;
    cyc(8);
    chk("ph_at0", 32'(phase_offset), 0);

    php(1023, 0);
    for (int v = 1022; v >= 512; v--) php(v, 1);
    phase_target = 10'd512;
    cyc(520);
    chk("ph_at512", 32'(phase_offset), 512);
    chk("ph_q_empty", phq.size(), 0);

    seg(100, 4, 1'b0);
    seg(110, 4, 1'b1);
    seg(120, 4, 1'b1);
    seg(130, 4, 1'b1);
    fin(130);
    go(100, 130, 10, 4, 1'b0);
    cyc(5);
    period_start = 999;
    period_end   = 500;
    start        = 1'b1;
    cyc(1);
    start        = 1'b0;
    cyc(20);
    chk("t1_empty", sb.size(), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_hold", period, 130);

    seg(50, 1, 1'b0);
    seg(40, 1, 1'b1);
    seg(30, 1, 1'b1);
    seg(27, 1, 1'b1);
    fin(27);
    go(50, 27, 10, 0, 1'b0);
    cyc(10);
    chk("t2_empty", sb.size(), 0);
    chk("t2_hold", period, 27);

    seg(5, 2, 1'b0);
    seg(6, 2, 1'b1);
    seg(7, 2, 1'b1);
    seg(5, 2, 1'b1);
    seg(6, 1, 1'b1);
    go(5, 7, 1, 2, 1'b1);
    cyc(8);
    abort = 1'b1;
    start = 1'b1;
    cyc(1);
    abort = 1'b0;
    start = 1'b0;
    chk("t3_busy", 32'(busy), 0);
    chk("t3_frozen", period, 6);
    chk("t3_nodone", 32'(done), 0);
    abort = 1'b1;
    start = 1'b1;
    cyc(1);
    abort = 1'b0;
    start = 1'b0;
    cyc(3);
    chk("t3_ign_busy", 32'(busy), 0);
    chk("t3_ign_period", period, 6);
    chk("t3_empty", sb.size(), 0);

    seg(80, 3, 1'b0);
    fin(80);
    go(80, 99, 0, 3, 1'b0);
    cyc(8);
    chk("t4_empty", sb.size(), 0);
    chk("t4_hold", period, 80);

`ifdef SINE_SWEEP_BIDIR_EN
    seg(0, 1, 1'b0);
    seg(1, 1, 1'b1);
    seg(2, 1, 1'b1);
    seg(1, 1, 1'b1);
    seg(0, 1, 1'b1);
    fin(0);
    go(0, 2, 1, 1, 1'b0);
    cyc(10);
    chk("bidir_empty", sb.size(), 0);
    chk("bidir_hold", period, 0);
`endif

    seg(200, 3, 1'b0);
    go(200, 300, 10, 5, 1'b0);
    cyc(3);
    rst = 1'b0;
    #1;
    chk("ar_period", period, 0);
    chk("ar_phase", 32'(phase_offset), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_strobe", 32'(step_strobe), 0);
    phase_target = 10'd0;
    cyc(2);
    rst = 1'b1;
    cyc(4);
    chk("ar_idle", 32'(busy), 0);
    chk("ar_q_empty", sb.size(), 0);
    chk("ar_ph_q_empty", phq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
